shift_unit: RTL

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/shift_unit.sv
// shift_unit: 32-bit SLL / SRL / SRA / pass-through shifter with a
// start/busy/done handshake. By default the shift is serial (one bit per
// cycle). Defining the macro SHIFT_FAST_EN replaces it with a single-cycle
// barrel shift computed at acceptance; results are identical either way.
module shift_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data_in,
  input  logic [31:0] shamt,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_result;
  logic        w_accept;
  logic [4:0]  w_n;
  logic        w_pass;
  logic        w_unused_shamt;

  // Only the low five bits of the amount are meaningful.
  assign w_n            = shamt[4:0];
  assign w_pass         = (op == OP_PASS);
  assign w_unused_shamt = ^shamt[31:5];

  // A new request is taken whenever no shift is in flight.
  assign w_accept = start && (r_state != ST_SHIFT);

`ifdef SHIFT_FAST_EN
  logic [31:0] w_fast;

  // Full-width shift of the incoming operand by the requested amount.
  always_comb begin
    w_fast = data_in;
    unique case (op)
      OP_SLL:  w_fast = data_in << w_n;
      OP_SRL:  w_fast = data_in >> w_n;
      OP_SRA:  w_fast = $unsigned($signed(data_in) >>> w_n);
      default: w_fast = data_in;
    endcase
  end

  // Result register: loaded once with the finished value on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_accept) begin
      r_result <= w_fast;
    end
  end
`else
  logic [1:0]  r_op;
  logic [4:0]  r_cnt;
  logic [31:0] w_step;

  // One-bit shift of the working value according to the latched op.
  always_comb begin
    w_step = r_result;
    unique case (r_op)
      OP_SLL:  w_step = {r_result[30:0], 1'b0};
      OP_SRL:  w_step = {1'b0, r_result[31:1]};
      OP_SRA:  w_step = {r_result[31], r_result[31:1]};
      default: w_step = r_result;
    endcase
  end

  // Datapath: load operand/op/count on acceptance, then shift and count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_op     <= OP_SLL;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_result <= data_in;
      r_op     <= op;
      r_cnt    <= w_n;
    end else if (r_state == ST_SHIFT) begin
      r_result <= w_step;
      r_cnt    <= r_cnt - 5'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
`ifdef SHIFT_FAST_EN
          w_next = ST_DONE;
`else
          w_next = ((w_n == 5'd0) || w_pass) ? ST_DONE : ST_SHIFT;
`endif
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
`ifdef SHIFT_FAST_EN
        w_next = ST_DONE;
`else
        w_next = (r_cnt == 5'd1) ? ST_DONE : ST_SHIFT;
`endif
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy   = (r_state == ST_SHIFT);
    done   = (r_state == ST_DONE);
    result = r_result;
  end

endmodule
